// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver (MM:SS) with active-low segments and digit enables.
// Optional adjust-field blinking is compiled in when SEG_BLINK_EN is defined.
module seg_display_mux #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] min1,
    input  logic [3:0] min2,
    input  logic [2:0] sec1,
    input  logic [3:0] sec2,
    input  logic       adj,
    input  logic       sel,
    output logic       seg1,
    output logic       seg2,
    output logic       seg3,
    output logic       seg4,
    output logic       seg5,
    output logic       seg6,
    output logic       seg7,
    output logic       dig1,
    output logic       dig2,
    output logic       dig3,
    output logic       dig4
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_idx;
    logic [6:0]        r_seg;
    logic [3:0]        r_dig;

    logic [3:0]        w_value;
    logic [3:0]        w_dig_code;
    logic [6:0]        w_seg_code;
    logic              w_blank;

    // Slot timer and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Digit select: value for the current slot and its active-low enable
    always_comb begin
        w_value    = 4'd0;
        w_dig_code = 4'b1111;
        case (r_idx)
            2'd0: begin w_value = {1'b0, min1}; w_dig_code = 4'b0111; end
            2'd1: begin w_value = min2;         w_dig_code = 4'b1011; end
            2'd2: begin w_value = {1'b0, sec1}; w_dig_code = 4'b1101; end
            default: begin w_value = sec2;      w_dig_code = 4'b1110; end
        endcase
    end

    // BCD to segments a..g (MSB = a), active-low; non-BCD shows a dash
    always_comb begin
        w_seg_code = 7'b1111110;
        case (w_value)
            4'd0: w_seg_code = 7'b0000001;
            4'd1: w_seg_code = 7'b1001111;
            4'd2: w_seg_code = 7'b0010010;
            4'd3: w_seg_code = 7'b0000110;
            4'd4: w_seg_code = 7'b1001100;
            4'd5: w_seg_code = 7'b0100100;
            4'd6: w_seg_code = 7'b0100000;
            4'd7: w_seg_code = 7'b0001111;
            4'd8: w_seg_code = 7'b0000000;
            4'd9: w_seg_code = 7'b0000100;
            default: w_seg_code = 7'b1111110;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Blink timer restarts visible whenever adjust mode is off
    always_ff @(posedge clk) begin
        if (reset || !adj) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Minutes occupy idx 0/1 (idx[1]=0), seconds idx 2/3 (idx[1]=1)
    assign w_blank = adj && !r_phase && (sel ? r_idx[1] : !r_idx[1]);
`else
    logic w_unused_adjust;
    assign w_unused_adjust = ^{adj, sel};
    assign w_blank         = 1'b0;
`endif

    // Registered outputs, one cycle behind the current slot and inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= 7'b1111111;
            r_dig <= 4'b1111;
        end else begin
            r_seg <= w_blank ? 7'b1111111 : w_seg_code;
            r_dig <= w_dig_code;
        end
    end

    assign {seg1, seg2, seg3, seg4, seg5, seg6, seg7} = r_seg;
    assign {dig1, dig2, dig3, dig4}                   = r_dig;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboarded bench for seg_display_mux: expected outputs are queued at stimulus time and
// checked by an independent monitor each clock. Blink expectations follow SEG_BLINK_EN.
module tb_seg_display_mux;

    localparam int unsigned SCAN  = 4;
    localparam int unsigned BLINK = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] min1;
    logic [3:0] min2;
    logic [2:0] sec1;
    logic [3:0] sec2;
    logic       adj;
    logic       sel;
    logic       seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic       dig1, dig2, dig3, dig4;

    seg_display_mux #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .reset(reset),
        .min1(min1), .min2(min2), .sec1(sec1), .sec2(sec2),
        .adj(adj), .sel(sel),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .seg5(seg5), .seg6(seg6), .seg7(seg7),
        .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q[$];
    logic [6:0]  seg_tab[16];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          done   = 1'b0;

    // Reference state: clocks since reset release, and consecutive adjust clocks so far
    int m_n   = 0;
    int m_run = 0;

    task automatic drive(input bit r, input bit a, input bit s,
                         input logic [2:0] m1, input logic [3:0] m2,
                         input logic [2:0] s1, input logic [3:0] s2);
        int          slot;
        logic [3:0]  v;
        logic [6:0]  es;
        logic [3:0]  ed;
        reset = r; adj = a; sel = s;
        min1 = m1; min2 = m2; sec1 = s1; sec2 = s2;
        if (r) begin
            es = 7'b1111111;
            ed = 4'b1111;
        end else begin
            slot = (m_n / SCAN) % 4;
            case (slot)
                0: v = {1'b0, m1};
                1: v = m2;
                2: v = {1'b0, s1};
                default: v = s2;
            endcase
            es = seg_tab[v];
            ed = 4'b1111;
            ed[3 - slot] = 1'b0;
`ifdef SEG_BLINK_EN
            if (a && ((m_run / BLINK) % 2 == 1) && (s == (slot >= 2)))
                es = 7'b1111111;
`endif
        end
        exp_q.push_back({es, ed});
        if (r) begin
            m_n = 0; m_run = 0;
        end else begin
            m_n++;
            m_run = a ? m_run + 1 : 0;
        end
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new output every clock
    initial begin
        logic [10:0] got, want;
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            got = {seg1, seg2, seg3, seg4, seg5, seg6, seg7, dig1, dig2, dig3, dig4};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output @%0t: got seg=%b dig=%b, no expectation queued",
                         $time, got[10:4], got[3:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL seg_dig @%0t: got seg=%b dig=%b, want seg=%b dig=%b",
                             $time, got[10:4], got[3:0], want[10:4], want[3:0]);
                end
            end
        end
    end

    initial begin
        bit         a, s;
        logic [2:0] m1, s1;
        logic [3:0] m2, s2;
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111110;

        // Reset then fixed 12:34 scan, adj toggling (ignored unless blink is built)
        drive(1, 0, 0, 3'd1, 4'd2, 3'd3, 4'd4);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 3'd1, 4'd2, 3'd3, 4'd4);
`ifndef SEG_BLINK_EN
        drive(1, 1, 0, 3'd1, 4'd2, 3'd3, 4'd4);
        for (int i = 0; i < 40; i++) drive(0, 1, 1'(i % 3 == 0), 3'd1, 4'd2, 3'd3, 4'd4);
`endif

        // Sweep units of seconds through all 16 codes, one full scan frame each
        drive(1, 0, 0, 3'd0, 4'd0, 3'd0, 4'd0);
        for (int v = 0; v < 16; v++)
            for (int k = 0; k < 4 * SCAN; k++) drive(0, 0, 0, 3'd5, 4'd9, 3'd0, 4'(v));

        // Blink on minutes over three half-periods
        drive(1, 0, 0, 3'd2, 4'd7, 3'd5, 4'd8);
        for (int i = 0; i < 50; i++) drive(0, 1, 0, 3'd2, 4'd7, 3'd5, 4'd8);

        // Field switch mid-blank, then reset mid-blink with adj still held
        drive(0, 0, 0, 3'd2, 4'd7, 3'd5, 4'd8);
        for (int i = 0; i < 60; i++)
            drive(i == 22, 1, i >= 20, 3'd2, 4'd7, 3'd5, 4'd8);

        // Randomized operation with occasional resets and mode changes
        a = 0; s = 0; m1 = 0; m2 = 0; s1 = 0; s2 = 0;
        drive(1, a, s, m1, m2, s1, s2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) a = ~a;
            if ($urandom_range(0, 9) == 0)  s = ~s;
            if ($urandom_range(0, 3) == 0)  m1 = 3'($urandom);
            if ($urandom_range(0, 3) == 0)  m2 = 4'($urandom);
            if ($urandom_range(0, 3) == 0)  s1 = 3'($urandom);
            if ($urandom_range(0, 3) == 0)  s2 = 4'($urandom);
            drive($urandom_range(0, 149) == 0, a, s, m1, m2, s1, s2);
        end

        done = 1'b1;
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot, >=2.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clocks per blink half-period, >=2.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports min1 input 3, min2 input 4, sec1 input 3, sec2 input 4: BCD digits, tens/units of minutes and seconds.
REQ-006 SHALL have port adj  input  1  adjust mode active.
REQ-007 SHALL have port sel  input  1  adjust field: 0 = minutes, 1 = seconds.
REQ-008 SHALL have ports seg1..seg7  output  1 each  segments a..g, active-low, registered.
REQ-009 SHALL have ports dig1..dig4  output  1 each  digit enables, active-low, registered; dig1 = min1 (leftmost) ... dig4 = sec2.

Function
REQ-010 SHALL hold a scan counter 0..SCAN_DIV-1, incrementing every clock, wrapping to 0 after SCAN_DIV-1.
REQ-011 SHALL hold 2-bit digit index idx, advancing 0->1->2->3->0 on the clock where scan counter = SCAN_DIV-1.
REQ-012 SHALL register outputs each clock from current idx and current inputs: one-cycle latency; exactly one dig low at any time out of reset.
REQ-013 SHALL map idx 0/1/2/3 to dig1/dig2/dig3/dig4 low with value min1/min2/sec1/sec2 (3-bit inputs zero-extended).
REQ-014 SHALL decode seg1..seg7 as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-015 SHALL display dash 1111110 for values 10-15.
REQ-016 SHALL sample input changes mid-slot on the next clock; no input latching per slot.
REQ-017 SHALL, with blink enabled (REQ-023), hold a blink counter 0..BLINK_DIV-1 and phase bit (1 = visible) toggling on wrap while adj=1.
REQ-018 SHALL clear blink counter to 0 and phase to 1 on every clock with adj=0; first blank phase starts BLINK_DIV clocks after adj rises.
REQ-019 SHALL, when adj=1 and phase=0, force seg1..seg7=1111111 for slots of the selected field (sel=0: idx 0,1; sel=1: idx 2,3); dig still driven low; other field unaffected.
REQ-020 SHALL apply sel changes during adj on the next clock without restarting the blink counter.

Reset
REQ-021 SHALL, on clock with reset=1: scan counter 0, idx 0, blink counter 0, phase 1, seg1..seg7=1111111, dig1..dig4=1111; overrides all other activity, including mid-slot and mid-blink.
REQ-022 SHALL, first clock after reset release, drive dig1=0 and seg for min1; slot length SCAN_DIV clocks from that point.

Configuration
REQ-023 SHALL compile blink logic only when SEG_BLINK_EN is defined; without it adj and sel are ignored, no blink counter exists, all digits always visible; port list identical in both builds.

Verification (SCAN_DIV=4, BLINK_DIV=16 unless stated)
REQ-024 SHALL check reset: reset=1 one clock -> seg=1111111, dig=1111; next clock dig1..4=0111.
REQ-025 SHALL check scan: min1=1,min2=2,sec1=3,sec2=4, adj=0 -> dig cycles 0111,1011,1101,1110 each 4 clocks; seg 1001111,0010010,0000110,1001100; repeats after 16 clocks.
REQ-026 SHALL check decode/dash: sweep sec2 0..15 while observing idx 3 -> table of REQ-014, 1111110 for 10-15.
REQ-027 SHALL check blink (SEG_BLINK_EN): adj=1, sel=0 -> dig1/dig2 segments 1111111 for clocks 16-31 after adj rise, visible 0-15 and 32-47; dig3/dig4 always visible.
REQ-028 SHALL check mid-operation: sel 0->1 at clock 20 of blink -> blanking moves to dig3/dig4 next clock; reset at clock 22 -> REQ-024 values, blink restarts visible.
REQ-029 SHALL check build without SEG_BLINK_EN: adj=1, sel toggling -> output identical to REQ-025 trace.
